// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Program counter and instruction fetch register for a small controller
//   core. The PC addresses an external synchronous program ROM. Each ROM byte
//   comes back one cycle later and is split into an instruction field and an
//   operand field.
//
// Ports
//   clk          in   single clock, all state updates on the rising edge
//   reset        in   synchronous, active-high
//   en_PC        in   PC increment enable
//   en_Fetch     in   fetch register capture enable
//   loact        in   PC load request (takes priority over en_PC)
//   rel          in   with loact: 0 = absolute load, 1 = PC-relative branch
//   load         in   absolute target, or two's-complement offset when rel=1
//   rom_addr     out  address to the program ROM (equals pc)
//   rom_data     in   ROM read data, one cycle behind rom_addr
//   pc           out  current program counter
//   program_byte out  rom_data passed straight through
//   instr        out  registered instruction field
//   oprnd        out  registered operand field
//   fetch_pc     out  address of the byte held in instr/oprnd
//   fetch_valid  out  one-cycle pulse on each capture
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                ADDR_W     = 12,
  parameter int                INSTR_W    = 4,
  parameter int                OPRND_W    = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  localparam int               BYTE_W     = INSTR_W + OPRND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_PC,
  input  logic              en_Fetch,
  input  logic              loact,
  input  logic              rel,
  input  logic [ADDR_W-1:0] load,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [BYTE_W-1:0] rom_data,
  output logic [ADDR_W-1:0] pc,
  output logic [BYTE_W-1:0] program_byte,
  output logic [INSTR_W-1:0] instr,
  output logic [OPRND_W-1:0] oprnd,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_valid
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  // Address whose data is currently presented on rom_data.
  logic [ADDR_W-1:0]  rom_pc_q;
  // rom_data is meaningless in the first cycle after reset.
  logic               dv_q;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [OPRND_W-1:0] oprnd_q, oprnd_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               capture;

  // The offset already spans the full PC width, so sign extension is the
  // identity and the modulo-2^ADDR_W add falls out of the truncating adder.
  always_comb begin
    pc_d = pc_q;
    if (loact) begin
      if (rel) pc_d = pc_q + load;
      else     pc_d = load;
    end else if (en_PC) begin
      pc_d = pc_q + 1'b1;
    end
  end

  assign capture = en_Fetch & dv_q;

  always_comb begin
    instr_d       = instr_q;
    oprnd_d       = oprnd_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = 1'b0;
    if (capture) begin
      instr_d       = rom_data[BYTE_W-1:OPRND_W];
      oprnd_d       = rom_data[OPRND_W-1:0];
      fetch_pc_d    = rom_pc_q;
      fetch_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_ADDR;
      rom_pc_q      <= RESET_ADDR;
      dv_q          <= 1'b0;
      instr_q       <= '0;
      oprnd_q       <= '0;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      rom_pc_q      <= pc_q;
      dv_q          <= 1'b1;
      instr_q       <= instr_d;
      oprnd_q       <= oprnd_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign rom_addr     = pc_q;
  assign pc           = pc_q;
  assign program_byte = rom_data;
  assign instr        = instr_q;
  assign oprnd        = oprnd_q;
  assign fetch_pc     = fetch_pc_q;
  assign fetch_valid  = fetch_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, en_PC, en_Fetch, loact, rel;
  logic [11:0] load;
  logic [11:0] rom_addr, pc, fetch_pc;
  logic [7:0]  rom_data, program_byte;
  logic [3:0]  instr, oprnd;
  logic        fetch_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(12), .INSTR_W(4), .OPRND_W(4), .RESET_ADDR(12'h000)) dut (
    .clk(clk), .reset(reset), .en_PC(en_PC), .en_Fetch(en_Fetch),
    .loact(loact), .rel(rel), .load(load), .rom_addr(rom_addr),
    .rom_data(rom_data), .pc(pc), .program_byte(program_byte),
    .instr(instr), .oprnd(oprnd), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid)
  );

  function automatic logic [7:0] memf(input logic [11:0] a);
    return a[7:0] + 8'h10;
  endfunction

  // Synchronous program ROM, one cycle of latency.
  always @(posedge clk) rom_data <= memf(rom_addr);

  // Reference model: the architectural view of the stage.
  logic [11:0] m_pc = '0;        // program counter
  logic [11:0] m_src = '0;       // address the ROM is currently returning
  logic        m_dv = 1'b0;      // that data is usable
  logic [3:0]  m_instr = '0, m_oprnd = '0;
  logic [11:0] m_fpc = '0;
  logic        m_fv = 1'b0;

  task automatic step(input logic r, input logic l, input logic rl,
                      input logic ep, input logic ef, input logic [11:0] ld);
    logic [7:0]  cur;
    logic [11:0] old_pc;
    reset = r; loact = l; rel = rl; en_PC = ep; en_Fetch = ef; load = ld;
    @(posedge clk);
    cur    = memf(m_src);
    old_pc = m_pc;
    if (r) begin
      m_pc = 12'h000; m_dv = 1'b0; m_instr = '0; m_oprnd = '0;
      m_fpc = '0; m_fv = 1'b0;
    end else begin
      m_fv = ef && m_dv;
      if (m_fv) begin
        m_instr = cur[7:4];
        m_oprnd = cur[3:0];
        m_fpc   = m_src;
      end
      if (l)       m_pc = rl ? 12'(old_pc + ld) : ld;
      else if (ep) m_pc = 12'(old_pc + 12'd1);
      m_dv = 1'b1;
    end
    m_src = old_pc;
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0, 1, 1, 12'(($urandom)));
    step(1, 1, 1, 1, 1, 12'(($urandom)));
    n_vec++; if (pc !== 12'h000)       begin n_err++; $display("FAIL reset_pc got %h want 000", pc); end
    n_vec++; if (rom_addr !== 12'h000) begin n_err++; $display("FAIL reset_rom_addr got %h want 000", rom_addr); end
    n_vec++; if (instr !== 4'h0)       begin n_err++; $display("FAIL reset_instr got %h want 0", instr); end
    n_vec++; if (oprnd !== 4'h0)       begin n_err++; $display("FAIL reset_oprnd got %h want 0", oprnd); end
    n_vec++; if (fetch_pc !== 12'h000) begin n_err++; $display("FAIL reset_fetch_pc got %h want 000", fetch_pc); end
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fetch_valid got %b want 0", fetch_valid); end
  endtask

  task automatic test_sequential();
    step(0, 0, 0, 1, 1, 12'h000);
    n_vec++; if (pc !== 12'h001 || fetch_valid !== 1'b0)
      begin n_err++; $display("FAIL seq_e1 got pc=%h fv=%b want pc=001 fv=0", pc, fetch_valid); end
    step(0, 0, 0, 1, 1, 12'h000);
    n_vec++; if (pc !== 12'h002 || instr !== 4'h1 || oprnd !== 4'h0 || fetch_pc !== 12'h000 || fetch_valid !== 1'b1)
      begin n_err++; $display("FAIL seq_e2 got pc=%h i=%h o=%h fpc=%h fv=%b want 002 1 0 000 1", pc, instr, oprnd, fetch_pc, fetch_valid); end
    step(0, 0, 0, 1, 1, 12'h000);
    n_vec++; if (pc !== 12'h003 || instr !== 4'h1 || oprnd !== 4'h1 || fetch_pc !== 12'h001 || fetch_valid !== 1'b1)
      begin n_err++; $display("FAIL seq_e3 got pc=%h i=%h o=%h fpc=%h fv=%b want 003 1 1 001 1", pc, instr, oprnd, fetch_pc, fetch_valid); end
  endtask

  task automatic test_abs_load();
    step(0, 1, 0, 0, 1, 12'h005);
    n_vec++; if (pc !== 12'h005) begin n_err++; $display("FAIL abs_to_005 got %h want 005", pc); end
    step(0, 1, 0, 1, 1, 12'h010);
    n_vec++; if (pc !== 12'h010) begin n_err++; $display("FAIL abs_ignores_enpc got %h want 010", pc); end
    step(0, 0, 0, 1, 1, 12'h000);
    // Byte at the pre-load address is still delivered after the load.
    n_vec++; if (fetch_pc !== 12'h005 || instr !== 4'h1 || oprnd !== 4'h5 || fetch_valid !== 1'b1)
      begin n_err++; $display("FAIL abs_inflight got fpc=%h i=%h o=%h fv=%b want 005 1 5 1", fetch_pc, instr, oprnd, fetch_valid); end
    step(0, 0, 0, 1, 1, 12'h000);
    n_vec++; if (fetch_pc !== 12'h010 || instr !== 4'h2 || oprnd !== 4'h0)
      begin n_err++; $display("FAIL abs_target got fpc=%h i=%h o=%h want 010 2 0", fetch_pc, instr, oprnd); end
  endtask

  task automatic test_rel_branch();
    step(0, 1, 0, 0, 0, 12'h010);
    step(0, 1, 1, 1, 0, 12'hFFE);
    n_vec++; if (pc !== 12'h00E) begin n_err++; $display("FAIL rel_back got %h want 00E", pc); end
    step(0, 1, 0, 0, 0, 12'hFFF);
    step(0, 1, 1, 0, 0, 12'h002);
    n_vec++; if (pc !== 12'h001) begin n_err++; $display("FAIL rel_wrap got %h want 001", pc); end
    step(0, 1, 0, 0, 0, 12'hFFF);
    step(0, 0, 0, 1, 0, 12'h000);
    n_vec++; if (pc !== 12'h000) begin n_err++; $display("FAIL inc_wrap got %h want 000", pc); end
    step(0, 0, 0, 0, 0, 12'h123);
    n_vec++; if (pc !== 12'h000) begin n_err++; $display("FAIL hold got %h want 000", pc); end
  endtask

  task automatic test_fetch_hold();
    logic [3:0]  si, so;
    logic [11:0] sf;
    step(0, 1, 0, 0, 1, 12'h040);
    step(0, 0, 0, 1, 1, 12'h000);
    step(0, 0, 0, 1, 1, 12'h000);
    si = m_instr; so = m_oprnd; sf = m_fpc;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 0, 12'h000);
      n_vec++; if (instr !== si || oprnd !== so || fetch_pc !== sf || fetch_valid !== 1'b0)
        begin n_err++; $display("FAIL hold_k%0d got i=%h o=%h fpc=%h fv=%b want %h %h %h 0", k, instr, oprnd, fetch_pc, fetch_valid, si, so, sf); end
      n_vec++; if (program_byte !== memf(m_src))
        begin n_err++; $display("FAIL hold_pbyte_k%0d got %h want %h", k, program_byte, memf(m_src)); end
    end
  endtask

  task automatic test_mid_reset();
    step(0, 1, 0, 1, 1, 12'h0A3);
    step(0, 0, 0, 1, 1, 12'h000);
    step(1, 1, 1, 1, 1, 12'h777);
    n_vec++; if (pc !== 12'h000 || instr !== 4'h0 || oprnd !== 4'h0 || fetch_pc !== 12'h000 || fetch_valid !== 1'b0)
      begin n_err++; $display("FAIL midrst got pc=%h i=%h o=%h fpc=%h fv=%b want all 0", pc, instr, oprnd, fetch_pc, fetch_valid); end
    step(0, 0, 0, 1, 1, 12'h000);
    n_vec++; if (fetch_valid !== 1'b0 || pc !== 12'h001)
      begin n_err++; $display("FAIL midrst_rel1 got fv=%b pc=%h want 0 001", fetch_valid, pc); end
    step(0, 0, 0, 1, 1, 12'h000);
    n_vec++; if (fetch_valid !== 1'b1 || fetch_pc !== 12'h000 || instr !== 4'h1)
      begin n_err++; $display("FAIL midrst_rel2 got fv=%b fpc=%h i=%h want 1 000 1", fetch_valid, fetch_pc, instr); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) != 0), 12'($urandom));
      n_vec++; if (pc !== m_pc || rom_addr !== m_pc)
        begin n_err++; $display("FAIL rnd_pc k=%0d got pc=%h ra=%h want %h", k, pc, rom_addr, m_pc); end
      n_vec++; if (instr !== m_instr || oprnd !== m_oprnd || fetch_pc !== m_fpc || fetch_valid !== m_fv)
        begin n_err++; $display("FAIL rnd_fetch k=%0d got i=%h o=%h fpc=%h fv=%b want %h %h %h %b", k, instr, oprnd, fetch_pc, fetch_valid, m_instr, m_oprnd, m_fpc, m_fv); end
      n_vec++; if (program_byte !== memf(m_src))
        begin n_err++; $display("FAIL rnd_pbyte k=%0d got %h want %h", k, program_byte, memf(m_src)); end
    end
  endtask

  initial begin
    reset = 1'b1; en_PC = 1'b0; en_Fetch = 1'b0; loact = 1'b0; rel = 1'b0; load = '0;
    test_reset();
    test_sequential();
    test_abs_load();
    test_rel_branch();
    test_fetch_hold();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
